// File: rtl/slave_mem_responder.sv
// Word-addressed memory slave for a crossbar port: accepts one request at a time,
// waits WAIT_CYCLES, pulses ack. Define MEM_RESET_EN to make reset also clear the memory.
module slave_mem_responder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slave_req,
    input  logic        slave_cmd,
    input  logic [31:0] slave_addr,
    input  logic [31:0] slave_wdata,
    output logic [31:0] slave_rdata,
    output logic        slave_ack,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_TURN} state_t;

    state_t                  state_r, next_state_s;
    logic [3:0]              cnt_r;
    logic                    cmd_r;
    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [31:0]             wdata_r;
    logic [31:0]             rdata_r;
    logic                    ack_r;
    logic                    busy_r;
    logic [31:0]             mem_r [DEPTH];

    logic                    accept_s;
    logic                    enter_ack_s;
    logic                    op_cmd_s;
    logic [DEPTH_LOG2-1:0]   op_idx_s;
    logic [31:0]             op_wdata_s;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{slave_addr[31:DEPTH_LOG2+2], slave_addr[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; in IDLE the live inputs feed ACK entry directly when there are no wait states
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        op_cmd_s     = cmd_r;
        op_idx_s     = idx_r;
        op_wdata_s   = wdata_r;
        case (state_r)
            ST_IDLE: begin
                op_cmd_s   = slave_cmd;
                op_idx_s   = slave_addr[DEPTH_LOG2+1:2];
                op_wdata_s = slave_wdata;
                if (slave_req) begin
                    accept_s     = 1'b1;
                    next_state_s = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_ACK;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ACK:  next_state_s = ST_TURN;
            ST_TURN: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        enter_ack_s = (next_state_s == ST_ACK);
    end

    // Transaction latch, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 4'd0;
            cmd_r   <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'h0;
            rdata_r <= 32'h0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                cmd_r   <= slave_cmd;
                idx_r   <= slave_addr[DEPTH_LOG2+1:2];
                wdata_r <= slave_wdata;
                cnt_r   <= WAIT_LOAD;
            end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            ack_r   <= enter_ack_s;
            rdata_r <= (enter_ack_s && !op_cmd_s) ? mem_r[op_idx_s] : 32'h0;
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

`ifdef MEM_RESET_EN
    // Memory array, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (enter_ack_s && op_cmd_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end else begin
            mem_r <= mem_r;
        end
    end
`else
    // Memory array; reset only blocks a write landing on the same edge
    always_ff @(posedge clk) begin
        if (!reset && enter_ack_s && op_cmd_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end
`endif

    assign slave_rdata = rdata_r;
    assign slave_ack   = ack_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Directed bench for slave_mem_responder: one instance with WAIT_CYCLES=2, one with 0.
module tb_slave_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req, cmd;
    logic [31:0] addr, wdata, rdata;
    logic        ack, busy;

    logic        req0, cmd0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ack0, busy0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    slave_mem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .slave_req(req), .slave_cmd(cmd),
        .slave_addr(addr), .slave_wdata(wdata), .slave_rdata(rdata),
        .slave_ack(ack), .busy(busy)
    );

    slave_mem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .slave_req(req0), .slave_cmd(cmd0),
        .slave_addr(addr0), .slave_wdata(wdata0), .slave_rdata(rdata0),
        .slave_ack(ack0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One transaction on the WAIT_CYCLES=2 instance with cycle-exact ack/busy checks
    task automatic txn(input string tag, input logic c, input logic [31:0] a,
                       input logic [31:0] wd, input logic drop_early, output logic [31:0] r);
        req = 1'b1; cmd = c; addr = a; wdata = wd;
        tick;                                   // E0
        if (drop_early) req = 1'b0;
        addr = 32'hffff_fffc; wdata = 32'hdead_beef; cmd = ~c;
        check({tag, " ack@E0"},   {31'd0, ack},  32'd0);
        check({tag, " busy@E0"},  {31'd0, busy}, 32'd1);
        tick;                                   // E0+1
        check({tag, " ack@E0+1"}, {31'd0, ack},  32'd0);
        tick;                                   // E0+2
        check({tag, " ack@E0+2"}, {31'd0, ack},  32'd1);
        r = rdata;
        if (c) check({tag, " wr rdata"}, rdata, 32'h0);
        req = 1'b0;
        tick;                                   // TURN
        check({tag, " ack@turn"},   {31'd0, ack},  32'd0);
        check({tag, " rdata@turn"}, rdata,         32'h0);
        check({tag, " busy@turn"},  {31'd0, busy}, 32'd1);
        tick;                                   // IDLE
        check({tag, " busy@idle"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0; cmd = 1'b0; addr = 32'h0; wdata = 32'h0;
        req0 = 1'b0; cmd0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        tick; tick;
        check("rst ack",    {31'd0, ack},  32'd0);
        check("rst busy",   {31'd0, busy}, 32'd0);
        check("rst rdata",  rdata,         32'h0);
        check("rst ack0",   {31'd0, ack0}, 32'd0);
        check("rst busy0",  {31'd0, busy0}, 32'd0);
        reset = 1'b0;
        tick;

        txn("wr4", 1'b1, 32'h0000_0004, 32'h000f_eed0, 1'b0, rd);
        txn("rd4", 1'b0, 32'h8000_0004, 32'h0, 1'b0, rd);
        check("rd4 data", rd, 32'h000f_eed0);
        txn("rd7", 1'b0, 32'h0000_0007, 32'h0, 1'b0, rd);
        check("unaligned data", rd, 32'h000f_eed0);

        txn("wr0", 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, rd);
        txn("rd0drop", 1'b0, 32'h0000_0000, 32'h0, 1'b1, rd);
        check("req drop data", rd, 32'h1234_5678);

        // Reset during WAIT discards the write
        txn("wr8", 1'b1, 32'h0000_0008, 32'haaaa_0002, 1'b0, rd);
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0008; wdata = 32'hfeed_00c0;
        tick;                                   // E0
        req = 1'b0; reset = 1'b1;
        tick;                                   // reset edge
        reset = 1'b0;
        check("rstwait busy", {31'd0, busy}, 32'd0);
        check("rstwait ack",  {31'd0, ack},  32'd0);
        tick;                                   // would-be ack edge
        check("rstwait noack", {31'd0, ack}, 32'd0);
        tick;
        txn("rd8", 1'b0, 32'h0000_0008, 32'h0, 1'b0, rd);
        check("rstwait old data", rd, 32'haaaa_0002);

        // Reset beats acceptance at the same edge
        req = 1'b1; cmd = 1'b0; addr = 32'h0000_0004; reset = 1'b1;
        tick;
        req = 1'b0; reset = 1'b0;
        check("rstprio busy", {31'd0, busy}, 32'd0);
        tick; tick;
        check("rstprio ack", {31'd0, ack}, 32'd0);

        // Memory behaviour across reset
        txn("wr12", 1'b1, 32'h0000_000c, 32'hfeed_00c1, 1'b0, rd);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        txn("rd12", 1'b0, 32'h0000_000c, 32'h0, 1'b0, rd);
`ifdef MEM_RESET_EN
        check("memrst data", rd, 32'h0);
`else
        check("memrst data", rd, 32'hfeed_00c1);
`endif

        // Back-to-back on the zero-wait instance
        req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'h0000_0004; wdata0 = 32'h000f_eed1;
        tick;                                   // E0 -> ACK
        check("b2b wr ack",   {31'd0, ack0},  32'd1);
        check("b2b wr rdata", rdata0,         32'h0);
        cmd0 = 1'b0; wdata0 = 32'h0;
        tick;                                   // TURN
        check("b2b turn ack",  {31'd0, ack0},  32'd0);
        check("b2b turn busy", {31'd0, busy0}, 32'd1);
        tick;                                   // IDLE
        check("b2b idle busy", {31'd0, busy0}, 32'd0);
        check("b2b idle ack",  {31'd0, ack0},  32'd0);
        tick;                                   // E0+3 -> ACK
        check("b2b rd ack",   {31'd0, ack0}, 32'd1);
        check("b2b rd data",  rdata0,        32'h000f_eed1);
        req0 = 1'b0;
        tick;
        check("b2b rd clear", rdata0, 32'h0);
        tick;
        check("b2b end busy", {31'd0, busy0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
